led_sequencer: RTL and testbench



---
 rtl/led_seq_pkg.sv | 17 +
 rtl/led_tick_gen.sv | 27 ++
 rtl/led_sequencer.sv | 168 ++++++++++++++++
 tb/tb_led_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared pattern-mode and FSM-state encodings for the LED sequencer.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT  = 2'd0,
    MODE_WALK   = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/led_tick_gen.sv
// Step-rate prescaler: counts 0..DIV-1 and flags the terminal count as tick.
module led_tick_gen #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// Runs a commanded LED pattern at a prescaled step rate on the LED bank.
// Optional build macro LED_SEQ_PWM_EN adds BRIGHT-controlled PWM dimming.
module led_sequencer #(
  parameter int unsigned CLK_HZ     = 27000000,
  parameter int unsigned STEP_HZ    = 4,
  parameter int unsigned WIDTH      = 6,
  parameter bit          ACTIVE_LOW = 1'b1
`ifdef LED_SEQ_PWM_EN
  ,
  parameter int unsigned BRIGHT     = 4
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [7:0]       cmd_steps,
  input  logic             abort,
  output logic [WIDTH-1:0] led,
  output logic             busy,
  output logic             done
);

  import led_seq_pkg::*;

  localparam int unsigned DIV = CLK_HZ / STEP_HZ;

  if (DIV < 2) begin : g_bad_div
    $error("led_sequencer: CLK_HZ/STEP_HZ must be at least 2");
  end
  if (WIDTH < 2) begin : g_bad_width
    $error("led_sequencer: WIDTH must be at least 2");
  end
`ifdef LED_SEQ_PWM_EN
  if (BRIGHT > 15) begin : g_bad_bright
    $error("led_sequencer: BRIGHT must be 0..15");
  end
`endif

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [7:0]       left_q, left_d;
  logic             inf_q, inf_d;
  logic [WIDTH-1:0] p_q, p_d, p_adv;
  logic             dir_q, dir_d, dir_adv;
  logic [WIDTH-1:0] led_d, lit, lit_mask;
  logic             tick;

  led_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_q != ST_RUN),
    .tick (tick)
  );

`ifdef LED_SEQ_PWM_EN
  logic [3:0] pwm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
    end
  end

  assign lit_mask = (32'(pwm_cnt) < BRIGHT) ? '1 : '0;
`else
  assign lit_mask = '1;
`endif

  // Bounce flips direction on the step that lands on an end bit, so each end is shown once.
  always_comb begin
    p_adv   = p_q;
    dir_adv = dir_q;
    case (mode_q)
      MODE_COUNT: p_adv = p_q + WIDTH'(1);
      MODE_WALK:  p_adv = {p_q[WIDTH-2:0], p_q[WIDTH-1]};
      MODE_BOUNCE: begin
        if (dir_q) begin
          p_adv = p_q << 1;
          if (p_adv[WIDTH-1]) dir_adv = 1'b0;
        end else begin
          p_adv = p_q >> 1;
          if (p_adv[0]) dir_adv = 1'b1;
        end
      end
      MODE_BLINK: p_adv = ~p_q;
      default:    p_adv = p_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    left_d  = left_q;
    inf_d   = inf_q;
    p_d     = p_q;
    dir_d   = dir_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          mode_d  = mode_e'(cmd_mode);
          left_d  = cmd_steps;
          inf_d   = (cmd_steps == 8'd0);
          dir_d   = 1'b1;
          state_d = ST_RUN;
          case (mode_e'(cmd_mode))
            MODE_COUNT:  p_d = '0;
            MODE_WALK:   p_d = WIDTH'(1);
            MODE_BOUNCE: p_d = WIDTH'(1);
            MODE_BLINK:  p_d = '1;
            default:     p_d = '0;
          endcase
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (!inf_q && (left_q == 8'd1)) begin
            state_d = ST_DONE;
          end else begin
            p_d   = p_adv;
            dir_d = dir_adv;
            if (!inf_q) left_d = left_q - 8'd1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // LED register is loaded from next-state so the first pattern appears right after acceptance.
  always_comb begin
    lit   = '0;
    led_d = '0;
    if (state_d == ST_RUN) lit = p_d & lit_mask;
    led_d = ACTIVE_LOW ? ~lit : lit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_COUNT;
      left_q  <= '0;
      inf_q   <= 1'b0;
      p_q     <= '0;
      dir_q   <= 1'b1;
      led     <= {WIDTH{ACTIVE_LOW}};
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      left_q  <= left_d;
      inf_q   <= inf_d;
      p_q     <= p_d;
      dir_q   <= dir_d;
      led     <= led_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer: stimulus queues expected patterns, a monitor checks them.
`timescale 1ns/1ps
module tb_led_sequencer;

  localparam int unsigned CLK_HZ  = 40;
  localparam int unsigned STEP_HZ = 4;
  localparam int unsigned DIV     = CLK_HZ / STEP_HZ;
  localparam int unsigned WIDTH   = 6;
  localparam logic [WIDTH-1:0] OFF = '1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd_mode = 2'd0;
  logic [7:0]       cmd_steps = 8'd0;
  logic             abort = 1'b0;
  logic             cmd_ready, busy, done;
  logic [WIDTH-1:0] led;

  led_sequencer #(
    .CLK_HZ    (CLK_HZ),
    .STEP_HZ   (STEP_HZ),
    .WIDTH     (WIDTH),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_mode (cmd_mode),
    .cmd_steps(cmd_steps),
    .abort    (abort),
    .led      (led),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit               is_end;
    logic [WIDTH-1:0] led;
    int               len;
    bit               done;
    int               at;
  } item_t;

  item_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int acc = 0;
  logic [WIDTH-1:0] pv [0:10];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Active-low bank: the pin image of pattern p is ~p.
  function automatic void push_pat(input logic [WIDTH-1:0] p, input int len);
    item_t it;
    it.is_end = 1'b0; it.led = ~p; it.len = len; it.done = 1'b0; it.at = 0;
    sb.push_back(it);
  endfunction

  function automatic void push_end(input bit d, input int at);
    item_t it;
    it.is_end = 1'b1; it.led = OFF; it.len = 0; it.done = d; it.at = at;
    sb.push_back(it);
  endfunction

  always @(posedge clk) cyc++;

  // Monitor
  logic             busy_p = 1'b0;
  logic [WIDTH-1:0] led_p = '1;
  int               run = 0;
  item_t            cur, it_end;
  bit               have_cur = 1'b0;
  bit               post_done = 1'b0;

  always @(negedge clk) begin
    if (post_done) begin
      chk("ready_after_done", int'(cmd_ready), 1);
      post_done = 1'b0;
    end
    if (busy_p && !busy) begin
      if (have_cur) chk("pattern_len", run, cur.len);
      have_cur = 1'b0;
      chk("sb_nonempty_end", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        it_end = sb.pop_front();
        chk("end_kind", int'(it_end.is_end), 1);
        chk("end_done", int'(done), int'(it_end.done));
        chk("end_led", int'(led), int'(OFF));
        chk("end_ready", int'(cmd_ready), it_end.done ? 0 : 1);
        if (it_end.done) begin
          // cycle 1 is the one right after the accepting edge
          chk("done_time", cyc - acc + 1, it_end.at);
          post_done = 1'b1;
        end
      end
    end else begin
      chk("no_stray_done", int'(done), 0);
      if (busy && (!busy_p || led != led_p)) begin
        if (have_cur) chk("pattern_len", run, cur.len);
        chk("sb_nonempty_pat", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          cur = sb.pop_front();
          have_cur = 1'b1;
          run = 1;
          chk("pat_kind", int'(cur.is_end), 0);
          chk("pat_led", int'(led), int'(cur.led));
        end else begin
          have_cur = 1'b0;
        end
      end else if (busy) begin
        run++;
      end
    end
    busy_p = busy;
    led_p  = led;
  end

  task automatic wait_ready(input int budget, input string what);
    int n = 0;
    while (!cmd_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(what, int'(cmd_ready), 1);
  endtask

  task automatic send(input logic [1:0] m, input logic [7:0] n);
    @(negedge clk);
    cmd_mode = m; cmd_steps = n; cmd_valid = 1'b1;
    wait_ready(50, "accept_timeout");
    @(posedge clk);
    #1;
    acc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic run_finite(input logic [1:0] m, input int n);
    for (int i = 0; i < n; i++) push_pat(pv[i], DIV);
    push_end(1'b1, DIV * n + 1);
    send(m, 8'(n));
    wait_ready(DIV * n + 20, "run_timeout");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, sb depth %0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_led", int'(led), int'(OFF));
    chk("reset_busy", int'(busy), 0);
    chk("reset_ready", int'(cmd_ready), 1);
    chk("reset_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    pv = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
    run_finite(2'd0, 5);

    pv = '{6'd1, 6'd2, 6'd4, 6'd8, 6'd16, 6'd32, 6'd1, 6'd0, 6'd0, 6'd0, 6'd0};
    run_finite(2'd1, 7);

    pv = '{6'd1, 6'd2, 6'd4, 6'd8, 6'd16, 6'd32, 6'd16, 6'd8, 6'd4, 6'd2, 6'd1};
    run_finite(2'd2, 11);

    // Abort together with cmd_valid in IDLE: command still accepted, single-step walk.
    push_pat(6'd1, DIV);
    push_end(1'b1, DIV + 1);
    abort = 1'b1;
    send(2'd1, 8'd1);
    abort = 1'b0;
    wait_ready(DIV + 20, "run_timeout");

    // Endless blink, stray command during RUN, abort in cycle 35.
    push_pat(6'h3F, DIV); push_pat(6'h00, DIV); push_pat(6'h3F, DIV); push_pat(6'h00, 5);
    push_end(1'b0, 0);
    send(2'd3, 8'd0);
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      if (k == 15) begin cmd_mode = 2'd0; cmd_steps = 8'd3; cmd_valid = 1'b1; end
      if (k == 20) chk("ready_in_run", int'(cmd_ready), 0);
      if (k == 30) cmd_valid = 1'b0;
      if (k == 35) abort = 1'b1;
    end
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_led", int'(led), int'(OFF));
    wait_ready(5, "abort_idle_timeout");

    // Reset pulsed mid-run, then a fresh count starts from zero.
    push_pat(6'd0, DIV); push_pat(6'd1, DIV); push_pat(6'd2, 5);
    push_end(1'b0, 0);
    send(2'd0, 8'd20);
    for (int k = 1; k <= 25; k++) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_led", int'(led), int'(OFF));
    chk("rst_async_busy", int'(busy), 0);
    chk("rst_async_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    pv = '{6'd0, 6'd1, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
    run_finite(2'd0, 2);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
